// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: loads a word, applies shamt single-bit left shifts, pulses done.
// Optional serial tap outputs (ser_out/ser_valid) enabled by SHIFT_SEQ_SERIAL_OUT_EN.
module shift_seq_ctrl #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
`ifdef SHIFT_SEQ_SERIAL_OUT_EN
  ,
  output logic               ser_out,
  output logic               ser_valid
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [SHAMT_W-1:0] count;
  logic [1:0]         lmode;

  // load/shift register controls: sel=1 loads load_val, sel=0 shifts in shiftin
  logic               sel;
  logic               shiftin;
  logic [WIDTH-1:0]   load_val;

  always_comb begin
    state_nxt = state;
    sel       = 1'b1;
    load_val  = result;
    shiftin   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_val  = data_in;
          state_nxt = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        sel  = 1'b0;
        case (lmode)
          2'b01:   shiftin = 1'b1;
          2'b10:   shiftin = result[WIDTH-1];
          default: shiftin = 1'b0;
        endcase
        if (count == SHAMT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      lmode <= 2'b00;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        count <= shamt;
        lmode <= mode;
      end else if (state == SHIFT) begin
        count <= count - SHAMT_W'(1);
      end
    end
  end

  // The 32-bit load/shift register, driven only by the FSM controls above
  always_ff @(posedge clk) begin
    if (reset)    result <= '0;
    else if (sel) result <= load_val;
    else          result <= {result[WIDTH-2:0], shiftin};
  end

`ifdef SHIFT_SEQ_SERIAL_OUT_EN
  assign ser_valid = (state == SHIFT);
  assign ser_out   = ser_valid & result[WIDTH-1];
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed plan cases plus randomized commands
// checked against an arithmetic reference model (shift/rotate/fill on a 64-bit word).
module tb_shift_seq_ctrl;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         mode;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
`ifdef SHIFT_SEQ_SERIAL_OUT_EN
  logic               ser_out;
  logic               ser_valid;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .shamt    (shamt),
    .mode     (mode),
    .busy     (busy),
    .done     (done),
    .result   (result)
`ifdef SHIFT_SEQ_SERIAL_OUT_EN
    ,
    .ser_out  (ser_out),
    .ser_valid(ser_valid)
`endif
  );

  // Reference: n left shifts as one wide shift; rotate folds the overflow back, fill-ones ORs a low mask.
  function automatic logic [31:0] model(input logic [31:0] d, input int n, input logic [1:0] m);
    logic [63:0] w;
    logic [63:0] mask;
    w    = {32'b0, d} << n;
    mask = (64'd1 << n) - 64'd1;
    case (m)
      2'b01:   return w[31:0] | mask[31:0];
      2'b10:   return w[31:0] | w[63:32];
      default: return w[31:0];
    endcase
  endfunction

  // Drives one command starting now (caller must be in an IDLE cycle); returns cycles until done
  // (-1 on timeout) and the number of cycles busy was low while waiting. poke>0 re-pulses start
  // with junk data in that cycle.
  task automatic issue(input logic [31:0] d, input logic [4:0] n, input logic [1:0] m,
                       input int poke, output int lat, output int busy_low);
    bit got;
    got      = 0;
    busy_low = 0;
    lat      = 0;
    start    = 1'b1;
    data_in  = d;
    shamt    = n;
    mode     = m;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      start   = 1'b0;
      data_in = $urandom;
      shamt   = SHAMT_W'($urandom);
      mode    = 2'($urandom);
      lat++;
      if (!busy) busy_low++;
      if (done) begin
        got = 1;
        break;
      end
      if (lat == poke) start = 1'b1;
    end
    start = 1'b0;
    if (!got) lat = -1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    start   = 1'b1;
    data_in = 32'hDEAD_BEEF;
    shamt   = 5'd3;
    mode    = 2'b00;
    repeat (2) step();
    reset = 1'b0;
    start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result got=%h exp=00000000", result); end
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_start_dropped got_busy=%b exp=0", busy); end
  endtask

  task automatic test_logical;
    int lat, bl;
    issue(32'h0000_00F1, 5'd4, 2'b00, 0, lat, bl);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL logical_latency got=%0d exp=5", lat); end
    vectors++; if (bl !== 0) begin miscompares++; $display("FAIL logical_busy_low got=%0d exp=0", bl); end
    vectors++; if (result !== 32'h0000_0F10) begin miscompares++; $display("FAIL logical_result got=%h exp=00000f10", result); end
    step();
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL logical_idle got_busy=%b got_done=%b exp=0,0", busy, done); end
    vectors++; if (result !== 32'h0000_0F10) begin miscompares++; $display("FAIL logical_hold got=%h exp=00000f10", result); end
  endtask

  task automatic test_zero_and_ones;
    int lat, bl;
    issue(32'h8000_0001, 5'd0, 2'b00, 0, lat, bl);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    vectors++; if (result !== 32'h8000_0001) begin miscompares++; $display("FAIL zero_result got=%h exp=80000001", result); end
    step();
    issue(32'h8000_0001, 5'd3, 2'b01, 0, lat, bl);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL ones_latency got=%0d exp=4", lat); end
    vectors++; if (result !== 32'h0000_000F) begin miscompares++; $display("FAIL ones_result got=%h exp=0000000f", result); end
    step();
  endtask

  task automatic test_rotate;
    int lat, bl;
    issue(32'hF000_0001, 5'd31, 2'b10, 0, lat, bl);
    vectors++; if (lat !== 32) begin miscompares++; $display("FAIL rotate_latency got=%0d exp=32", lat); end
    vectors++; if (bl !== 0) begin miscompares++; $display("FAIL rotate_busy_low got=%0d exp=0", bl); end
    vectors++; if (result !== 32'hF800_0000) begin miscompares++; $display("FAIL rotate_result got=%h exp=f8000000", result); end
    step();
  endtask

  task automatic test_ignore_start;
    int lat, bl;
    logic [31:0] d;
    logic [1:0]  m;
    d = $urandom;
    m = 2'($urandom);
    issue(d, 5'd8, m, 3, lat, bl);
    vectors++; if (lat !== 9) begin miscompares++; $display("FAIL ignore_latency got=%0d exp=9", lat); end
    vectors++; if (result !== model(d, 8, m)) begin miscompares++; $display("FAIL ignore_result got=%h exp=%h", result, model(d, 8, m)); end
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore_not_queued got_busy=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat, bl;
    logic [31:0] d0, d1;
    d0 = $urandom;
    d1 = $urandom;
    issue(d0, 5'd2, 2'b01, 0, lat, bl);
    vectors++; if (result !== model(d0, 2, 2'b01)) begin miscompares++; $display("FAIL b2b_first got=%h exp=%h", result, model(d0, 2, 2'b01)); end
    step();
    issue(d1, 5'd5, 2'b10, 0, lat, bl);
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL b2b_latency got=%0d exp=6", lat); end
    vectors++; if (result !== model(d1, 5, 2'b10)) begin miscompares++; $display("FAIL b2b_second got=%h exp=%h", result, model(d1, 5, 2'b10)); end
    step();
  endtask

  task automatic test_reset_mid;
    int lat, bl, dones;
    logic [31:0] d;
    d       = $urandom;
    start   = 1'b1;
    data_in = d;
    shamt   = 5'd10;
    mode    = 2'b01;
    step();
    start = 1'b0;
    step();
    step();
    vectors++; if (result !== model(d, 2, 2'b01)) begin miscompares++; $display("FAIL mid_partial got=%h exp=%h", result, model(d, 2, 2'b01)); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL mid_reset_state got_busy=%b got_done=%b exp=0,0", busy, done); end
    vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL mid_reset_result got=%h exp=00000000", result); end
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (done || busy) dones++;
    end
    vectors++; if (dones !== 0) begin miscompares++; $display("FAIL mid_no_done got=%0d exp=0", dones); end
    d = $urandom;
    issue(d, 5'd7, 2'b00, 0, lat, bl);
    vectors++; if (lat !== 8) begin miscompares++; $display("FAIL mid_after_latency got=%0d exp=8", lat); end
    vectors++; if (result !== model(d, 7, 2'b00)) begin miscompares++; $display("FAIL mid_after_result got=%h exp=%h", result, model(d, 7, 2'b00)); end
    step();
  endtask

  task automatic test_random;
    int lat, bl, gap;
    logic [31:0] d, held;
    logic [4:0]  n;
    logic [1:0]  m;
    for (int k = 0; k < 24; k++) begin
      d = $urandom;
      n = 5'($urandom);
      m = 2'($urandom);
      issue(d, n, m, (k % 3 == 0) ? 1 : 0, lat, bl);
      vectors++; if (lat !== int'(n) + 1) begin miscompares++; $display("FAIL rand_latency k=%0d got=%0d exp=%0d", k, lat, int'(n) + 1); end
      vectors++; if (bl !== 0) begin miscompares++; $display("FAIL rand_busy_low k=%0d got=%0d exp=0", k, bl); end
      vectors++; if (result !== model(d, int'(n), m)) begin miscompares++; $display("FAIL rand_result k=%0d d=%h n=%0d m=%0d got=%h exp=%h", k, d, n, m, result, model(d, int'(n), m)); end
      held = model(d, int'(n), m);
      gap  = $urandom_range(0, 2);
      step();
      vectors++; if (busy !== 1'b0 || result !== held) begin miscompares++; $display("FAIL rand_idle k=%0d got_busy=%b got=%h exp_busy=0 exp=%h", k, busy, result, held); end
      repeat (gap) step();
    end
  endtask

`ifdef SHIFT_SEQ_SERIAL_OUT_EN
  task automatic test_serial;
    int nv, bad_idle, c;
    logic [31:0] d;
    logic [3:0]  seq;
    d        = 32'hA000_0000;
    nv       = 0;
    bad_idle = 0;
    seq      = '0;
    start    = 1'b1;
    data_in  = d;
    shamt    = 5'd4;
    mode     = 2'b00;
    c        = 0;
    do begin
      step();
      start = 1'b0;
      c++;
      if (ser_valid) begin
        if (nv < 4) seq[3 - nv] = ser_out;
        nv++;
      end else if (ser_out) begin
        bad_idle++;
      end
    end while (!done && c < 40);
    vectors++; if (nv !== 4) begin miscompares++; $display("FAIL serial_valid_count got=%0d exp=4", nv); end
    vectors++; if (seq !== 4'b1010) begin miscompares++; $display("FAIL serial_bits got=%b exp=1010", seq); end
    vectors++; if (bad_idle !== 0 || ser_valid !== 1'b0) begin miscompares++; $display("FAIL serial_quiet got_bad=%0d got_valid=%b exp=0,0", bad_idle, ser_valid); end
    step();
  endtask
`endif

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;
    shamt   = '0;
    mode    = 2'b00;
    test_reset();
    test_logical();
    test_zero_and_ones();
    test_rotate();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef SHIFT_SEQ_SERIAL_OUT_EN
    test_serial();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
